// File: rtl/ceres_param.sv
// ceres_param: shared widths, D-cache lower-level request/response types and memory responder states
package ceres_param;
  localparam int XLEN = 32;
  localparam int BLK_SIZE = 128;
  localparam int LOWX_MEM_WORDS = 16384;
  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    logic                uncached;
    logic                rw;
    logic [BLK_SIZE-1:0] data;
  } dlowX_req_t;
  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } dlowX_res_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lowx_mem_state_e;
endpackage

// File: rtl/lowx_mem_array.sv
// lowx_mem_array: line-organised RAM with per-word write enables and a combinational full-line read
module lowx_mem_array
  import ceres_param::*;
#(
  parameter int LINES = 4096
) (
  input  logic                       clk_i,
  input  logic [$clog2(LINES)-1:0]   i_idx,
  input  logic [BLK_SIZE/XLEN-1:0]   i_we,
  input  logic [BLK_SIZE-1:0]        i_wdata,
  output logic [BLK_SIZE-1:0]        o_rdata
);
  localparam int N = BLK_SIZE / XLEN;
  logic [N-1:0][XLEN-1:0] r_mem [LINES];
  always_ff @(posedge clk_i)
    for (int i = 0; i < N; i++)
      if (i_we[i]) r_mem[i_idx][i] <= i_wdata[i*XLEN +: XLEN];
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/lowx_mem_responder.sv
// lowx_mem_responder: D-cache lowX memory responder with fixed latency; define LOWX_MEM_JITTER_EN
// to add 0..7 LFSR-driven extra wait cycles per request.
module lowx_mem_responder
  import ceres_param::*;
#(
  parameter int MEM_WORDS = LOWX_MEM_WORDS,
  parameter int LATENCY   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  dlowX_req_t lowX_req_i,
  output dlowX_res_t lowX_res_o,
  output logic       busy_o
);
  localparam int N     = BLK_SIZE / XLEN;
  localparam int WB    = $clog2(XLEN / 8);
  localparam int BB    = $clog2(BLK_SIZE / 8);
  localparam int AB    = $clog2(MEM_WORDS) + WB;
  localparam int IW    = AB - BB;
  localparam int CW    = $clog2(LATENCY + 8);
  localparam int LINES = MEM_WORDS / N;
  lowx_mem_state_e     r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic                r_rw;
  logic                r_valid;
  logic                r_ready;
  logic                r_busy;
  logic [BLK_SIZE-1:0] r_data;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_mem_idx;
  logic [$clog2(N)-1:0] w_word;
  logic                w_accept;
  logic [N-1:0]        w_we;
  logic [BLK_SIZE-1:0] w_wdata;
  logic [BLK_SIZE-1:0] w_rdata;
  logic [2:0]          w_extra;
  logic [CW-1:0]       w_load;
  assign w_idx     = lowX_req_i.addr[AB-1:BB];
  assign w_word    = lowX_req_i.addr[BB-1:WB];
  assign w_accept  = (r_state == IDLE) && lowX_req_i.valid && r_ready;
  assign w_mem_idx = (r_state == IDLE) ? w_idx : r_idx;
  // writes commit at acceptance so a later read of the same line sees them
  assign w_we      = !(w_accept && lowX_req_i.rw) ? '0 :
                     lowX_req_i.uncached ? (N'(1) << w_word) : '1;
  assign w_wdata   = lowX_req_i.uncached ? {N{lowX_req_i.data[XLEN-1:0]}} : lowX_req_i.data;
  assign w_load    = CW'(LATENCY - 1) + CW'(w_extra);
`ifdef LOWX_MEM_JITTER_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk_i)
    if (rst_i) r_lfsr <= 8'hA5;
    else if (w_accept) r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
  assign w_extra = r_lfsr[2:0];
`else
  assign w_extra = '0;
`endif
  lowx_mem_array #(.LINES(LINES)) u_array (
    .clk_i   (clk_i),
    .i_idx   (w_mem_idx),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rw    <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_idx   <= w_idx;
          r_rw    <= lowX_req_i.rw;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_cnt   <= w_load;
          if (w_load == '0) begin
            r_state <= RESP;
            r_valid <= 1'b1;
            r_data  <= lowX_req_i.rw ? '0 : w_rdata;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: if (r_cnt == '0) begin
          r_state <= RESP;
          r_valid <= 1'b1;
          r_data  <= r_rw ? '0 : w_rdata;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        RESP: if (lowX_req_i.ready) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign lowX_res_o.valid = r_valid;
  assign lowX_res_o.ready = r_ready;
  assign lowX_res_o.data  = r_data;
  assign busy_o           = r_busy;
endmodule

// File: tb/tb_lowx_mem_responder.sv
// tb_lowx_mem_responder: directed self-checking bench for lowx_mem_responder
module tb_lowx_mem_responder;
  import ceres_param::*;
  localparam int LAT = 4;
  localparam logic [127:0] D1  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D1U = 128'h44444444_DEADBEEF_22222222_11111111;
  localparam logic [127:0] D2  = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  dlowX_req_t req;
  dlowX_res_t res;
  logic       busy;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_lfsr = 8'hA5;
  always #5 clk = ~clk;
  lowx_mem_responder #(.MEM_WORDS(16384), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .lowX_req_i (req),
    .lowX_res_o (res),
    .busy_o     (busy)
  );
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic int jit();
`ifdef LOWX_MEM_JITTER_EN
    return int'(m_lfsr[2:0]);
`else
    return 0;
`endif
  endfunction
  task automatic adv();
    m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  endtask
  // issues one request with req.ready held high; lat counts edges from acceptance edge to first valid
  task automatic xact(input logic [31:0] a, input logic w, input logic u, input logic [127:0] d,
                      output int lat, output logic [127:0] q, output int exp_lat);
    @(negedge clk);
    req.valid = 1'b1; req.addr = a; req.rw = w; req.uncached = u; req.data = d; req.ready = 1'b1;
    exp_lat = LAT + 1 + jit();
    adv();
    @(posedge clk); #1;
    req.valid = 1'b0;
    lat = 1;
    while (!res.valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = res.data;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (res.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", res.valid); end
    checks++; if (res.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", res.ready); end
    checks++; if (res.data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", res.data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 8'hA5;
  endtask
  task automatic test_cached_write();
    int lat, e;
    logic [127:0] q;
    xact(32'h1000, 1'b1, 1'b0, D1, lat, q, e);
    checks++; if (lat !== e) begin failures++; $display("FAIL cwr_latency got=%0d want=%0d", lat, e); end
    checks++; if (q !== '0) begin failures++; $display("FAIL cwr_data got=%h want=0", q); end
    xact(32'h1000, 1'b0, 1'b0, '0, lat, q, e);
    checks++; if (lat !== e) begin failures++; $display("FAIL crd_latency got=%0d want=%0d", lat, e); end
    checks++; if (q !== D1) begin failures++; $display("FAIL crd_data got=%h want=%h", q, D1); end
  endtask
  task automatic test_uncached_write();
    int lat, e;
    logic [127:0] q;
    xact(32'h1008, 1'b1, 1'b1, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hDEADBEEF}, lat, q, e);
    checks++; if (q !== '0) begin failures++; $display("FAIL uwr_data got=%h want=0", q); end
    xact(32'h1000, 1'b0, 1'b0, '0, lat, q, e);
    checks++; if (q !== D1U) begin failures++; $display("FAIL uwr_readback got=%h want=%h", q, D1U); end
  endtask
  task automatic test_hold_ready();
    int n;
    logic [127:0] d0;
    @(negedge clk);
    req.valid = 1'b1; req.addr = 32'h1000; req.rw = 1'b0; req.uncached = 1'b0; req.ready = 1'b0;
    adv();
    @(posedge clk); #1;
    req.valid = 1'b0;
    n = 1;
    while (!res.valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    d0 = res.data;
    checks++; if (d0 !== D1U) begin failures++; $display("FAIL hold_first_data got=%h want=%h", d0, D1U); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (res.valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b want=1", k, res.valid); end
      checks++; if (res.data !== D1U) begin failures++; $display("FAIL hold_data[%0d] got=%h want=%h", k, res.data, D1U); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy[%0d] got=%b want=1", k, busy); end
      checks++; if (res.ready !== 1'b0) begin failures++; $display("FAIL hold_ready[%0d] got=%b want=0", k, res.ready); end
    end
    @(negedge clk);
    req.ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (res.valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b want=0", res.valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_release_busy got=%b want=0", busy); end
    checks++; if (res.ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b want=1", res.ready); end
  endtask
  task automatic test_wait_pulse();
    int rises, lat, e;
    logic pv;
    logic [127:0] first, q;
    @(negedge clk);
    req.valid = 1'b1; req.addr = 32'h1000; req.rw = 1'b0; req.uncached = 1'b0; req.ready = 1'b1;
    adv();
    @(posedge clk); #1;
    req.valid = 1'b0;
    @(negedge clk);
    checks++; if (res.ready !== 1'b0) begin failures++; $display("FAIL wait_ready got=%b want=0", res.ready); end
    req.valid = 1'b1; req.rw = 1'b1; req.data = '1;
    @(negedge clk);
    req.valid = 1'b0; req.rw = 1'b0;
    rises = 0; pv = 1'b0; first = '0;
    repeat (24) begin
      @(posedge clk); #1;
      if (res.valid && !pv) begin rises++; if (rises == 1) first = res.data; end
      pv = res.valid;
    end
    checks++; if (rises !== 1) begin failures++; $display("FAIL wait_resp_count got=%0d want=1", rises); end
    checks++; if (first !== D1U) begin failures++; $display("FAIL wait_resp_data got=%h want=%h", first, D1U); end
    xact(32'h1000, 1'b0, 1'b0, '0, lat, q, e);
    checks++; if (q !== D1U) begin failures++; $display("FAIL wait_no_write got=%h want=%h", q, D1U); end
  endtask
  task automatic test_reset_mid();
    int lat, e;
    logic [127:0] q;
    @(negedge clk);
    req.valid = 1'b1; req.addr = 32'h2000; req.rw = 1'b1; req.uncached = 1'b0; req.data = D2; req.ready = 1'b1;
    adv();
    @(posedge clk); #1;
    req.valid = 1'b0; req.rw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (res.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", res.valid); end
    checks++; if (res.ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", res.ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 8'hA5;
    xact(32'h2000, 1'b0, 1'b0, '0, lat, q, e);
    checks++; if (lat !== e) begin failures++; $display("FAIL midrst_latency got=%0d want=%0d", lat, e); end
    checks++; if (q !== D2) begin failures++; $display("FAIL midrst_persist got=%h want=%h", q, D2); end
  endtask
  task automatic test_alias();
    int lat, e;
    logic [127:0] q;
    xact(32'h0001_1000, 1'b0, 1'b0, '0, lat, q, e);
    checks++; if (lat !== e) begin failures++; $display("FAIL alias_latency got=%0d want=%0d", lat, e); end
    checks++; if (q !== D1U) begin failures++; $display("FAIL alias_data got=%h want=%h", q, D1U); end
    xact(32'h0000_100C, 1'b0, 1'b1, '0, lat, q, e);
    checks++; if (q !== D1U) begin failures++; $display("FAIL uncached_read_line got=%h want=%h", q, D1U); end
    xact(32'h0000_2004, 1'b0, 1'b0, '0, lat, q, e);
    checks++; if (q !== D2) begin failures++; $display("FAIL line2_read got=%h want=%h", q, D2); end
  endtask
`ifdef LOWX_MEM_JITTER_EN
  task automatic test_jitter();
    int lat, e;
    logic [127:0] q;
    for (int k = 0; k < 16; k++) begin
      xact(32'h1000, 1'b0, 1'b0, '0, lat, q, e);
      checks++; if (lat !== e) begin failures++; $display("FAIL jitter_latency[%0d] got=%0d want=%0d", k, lat, e); end
    end
  endtask
`endif
  initial begin
    req = '0;
    req.ready = 1'b1;
    test_reset();
    test_cached_write();
    test_uncached_write();
    test_hold_ready();
    test_wait_pulse();
    test_reset_mid();
    test_alias();
`ifdef LOWX_MEM_JITTER_EN
    test_jitter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
